// File: rtl/fused_cnn_pkg.sv
// ---------------------------------------------------------------------------
// fused_cnn_pkg
// Shared definitions for the fused CNN datapath: the geometry of the
// feature/weight BRAM and the state type of the BRAM read streamer.
// No ports (package).
// ---------------------------------------------------------------------------
package fused_cnn_pkg;

    localparam int BRAM_DATA_W = 32;   // BRAM word width
    localparam int BRAM_ADDR_W = 20;   // byte-address width of BRAM read port
    localparam int BRAM_DEPTH  = 72;   // BRAM depth in words
    localparam int RD_CNT_W    = 7;    // width of a transfer word count

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// ---------------------------------------------------------------------------
// rd_skid_fifo
// Two-entry pointer-based FIFO sitting between the BRAM read data and the
// output stream. The owner guarantees it never pushes when full and never
// pops when empty, so no full/empty protection is built in.
// Ports:
//   clk, rst   clock, synchronous active-high reset (flushes and zeroes)
//   push       write push_data at the tail this cycle
//   push_data  W-bit entry to write
//   pop        drop the head entry this cycle
//   head       current head entry (contents of the read slot)
//   occ        number of valid entries, 0..2
// ---------------------------------------------------------------------------
module rd_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = slot[rd_ptr];

endmodule

// File: rtl/bram_rd_streamer.sv
// ---------------------------------------------------------------------------
// bram_rd_streamer
// Read-side client of the feature/weight BRAM. On start it walks num_words
// word-aligned byte addresses from base_addr, absorbs the BRAM's one-cycle
// read latency and streams the words in order on a valid/ready interface.
// A two-entry skid FIFO keeps one word per cycle under backpressure.
//
// Optional feature: define BRAM_RD_BOUNDS_CHK_EN to reject transfers that
// run past the end of the BRAM (err set, no reads issued). Without it err is
// tied low and out-of-range addresses are issued as-is.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin transfer (only looked at while idle)
//   base_addr      byte address of first word, bits [1:0] ignored
//   num_words      number of words to read, 0..DEPTH
//   busy           high while reading/draining
//   done           one-cycle pulse at end of transfer
//   err            sticky bounds error, cleared by next accepted start
//   bram_rd_addr   byte address to the BRAM read port
//   bram_we        BRAM write enable; reads cannot be issued while high
//   bram_rd_data   registered BRAM read data
//   m_valid/m_ready/m_data/m_last   output word stream
// ---------------------------------------------------------------------------
module bram_rd_streamer
    import fused_cnn_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W,
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int CNT_W  = RD_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic              bram_we,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    rd_state_t         state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  issued_q;
    logic              inflight_q;
    logic              inflight_last_q;

    logic [DATA_W:0]   fifo_head;
    logic [1:0]        occ;
    logic              pop;
    logic              issue;
    logic              issue_last;
    logic              drain_done;
    logic              oob;
    logic [ADDR_W-1:0] base_aligned;

    assign base_aligned = base_addr & ~ADDR_W'(3);
    assign pop          = m_valid & m_ready;

    // A read may only be issued if the FIFO is guaranteed a free slot when
    // its data lands next cycle: entries held plus the word already in
    // flight, minus the one leaving this cycle, must stay below two.
    assign issue = (state == ST_READ) && !bram_we &&
                   (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    assign issue_last = (issued_q == total_q - CNT_W'(1));

    // Transfer is complete once nothing is in flight and the FIFO is empty
    // or its single remaining (final) word is being taken this cycle.
    assign drain_done = !inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && pop));

`ifdef BRAM_RD_BOUNDS_CHK_EN
    logic [ADDR_W:0] end_word;
    logic            err_q;

    assign end_word = {3'b000, base_addr[ADDR_W-1:2]} + (ADDR_W+1)'(num_words);
    assign oob      = end_word > (ADDR_W+1)'(BRAM_DEPTH);

    // Error flag reflects the bounds result of the most recent accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            err_q <= oob;
        end
    end

    assign err = err_q;
`else
    assign oob = 1'b0;
    assign err = 1'b0;
`endif

    // Transfer sequencing. The address register only advances on an issued
    // read and is not bumped past the final word, so it holds the last
    // address issued once the transfer is over.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            addr_q          <= '0;
            total_q         <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue & issue_last;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        total_q  <= num_words;
                        issued_q <= '0;
                        if (oob) begin
                            state <= ST_FINISH;
                        end else begin
                            addr_q <= base_aligned;
                            state  <= (num_words == '0) ? ST_FINISH : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        issued_q <= issued_q + CNT_W'(1);
                        if (issue_last) begin
                            state <= ST_DRAIN;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(4);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Each FIFO entry carries its last-word flag alongside the data.
    rd_skid_fifo #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, bram_rd_data}),
        .pop       (pop),
        .head      (fifo_head),
        .occ       (occ)
    );

    assign bram_rd_addr = addr_q;
    assign busy         = (state == ST_READ) || (state == ST_DRAIN);
    assign done         = (state == ST_FINISH);
    assign m_valid      = (occ != 2'd0);
    assign m_data       = fifo_head[DATA_W-1:0];
    assign m_last       = fifo_head[DATA_W];

endmodule
